// File: rtl/fantasticfft_pkg.sv
// Shared FFT definitions: Q8.8 sample type, transform size and fixed-point helpers.
`ifndef FANTASTICFFT_FIX_MACROS
`define FANTASTICFFT_FIX_MACROS
`define FANTASTICFFT_FIX_CREATE(int_v) (16'((int_v) <<< 8))
`define FANTASTICFFT_FIX_TO_INT(fx) ($signed(fx) >>> 8)
`endif

package fantasticfft_pkg;
  typedef logic [7:-8] fixed_t;
  localparam int FFT_N = 8;
endpackage

// File: rtl/fantasticfft_fft8_framer_if.sv
// Sample stream in, parallel frame out; slave is the framer, master is its environment.
interface fantasticfft_fft8_framer_if;
  import fantasticfft_pkg::*;
  fixed_t s_data;
  logic   s_valid;
  logic   s_last;
  logic   s_ready;
  fixed_t x0, x1, x2, x3, x4, x5, x6, x7;
  logic   isValid;
  logic   fft_ready;
  logic   padded;

  modport slave (
    input  s_data, s_valid, s_last, fft_ready,
    output s_ready, x0, x1, x2, x3, x4, x5, x6, x7, isValid, padded
  );

  modport master (
    output s_data, s_valid, s_last, fft_ready,
    input  s_ready, x0, x1, x2, x3, x4, x5, x6, x7, isValid, padded
  );
endinterface

// File: rtl/fantasticfft_frame_bank.sv
// One frame buffer: eight sample registers, committed fill count and padded flag,
// with slots beyond the fill count reading as zero.
module fantasticfft_frame_bank
  import fantasticfft_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic                   close_i,
  input  logic [2:0]             wr_idx_i,
  input  fixed_t                 wr_data_i,
  input  logic                   pad_i,
  output fixed_t [FFT_N-1:0]     x_o,
  output logic                   padded_o
);
  fixed_t [FFT_N-1:0] mem_q;
  logic [3:0]         fill_q;
  logic               pad_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  // A zero fill count masks every slot, so clearing it is enough to blank the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= 4'd0;
      pad_q  <= 1'b0;
    end else if (close_i) begin
      fill_q <= {1'b0, wr_idx_i} + 4'd1;
      pad_q  <= pad_i;
    end
  end

  always_comb begin
    for (int i = 0; i < FFT_N; i++) begin
      x_o[i] = (4'(i) < fill_q) ? mem_q[i] : '0;
    end
  end

  assign padded_o = pad_q;
endmodule

// File: rtl/fantasticfft_fft8_framer.sv
// Groups a serial Q8.8 stream into 8-sample frames using two ping-pong banks and
// presents the oldest complete frame in parallel to the FFT8.
module fantasticfft_fft8_framer
  import fantasticfft_pkg::*;
#(
  parameter int INT_BITS  = 8,
  parameter int FRAC_BITS = 8,
  parameter int PRESCALE  = 0
) (
  input logic                          clk,
  input logic                          rst,
  fantasticfft_fft8_framer_if.slave    bus
);
  logic [1:0] nfull_q, nfull_d;
  logic       wbank_q, wbank_d;
  logic       rbank_q, rbank_d;
  logic [2:0] wr_idx_q, wr_idx_d;

  logic accept, close, rel, pad;
  logic signed [INT_BITS-1:-FRAC_BITS] scaled;
  fixed_t [FFT_N-1:0] bx0, bx1, xr;
  logic bpad0, bpad1;

  assign scaled  = $signed(bus.s_data) >>> PRESCALE;
  assign accept  = bus.s_valid && bus.s_ready;
  assign close   = accept && (bus.s_last || (wr_idx_q == 3'd7));
  assign pad     = bus.s_last && (wr_idx_q != 3'd7);
  assign rel     = bus.isValid && bus.fft_ready;

  // Ready depends only on occupancy, never on fft_ready.
  assign bus.s_ready = (nfull_q != 2'd2);
  assign bus.isValid = (nfull_q != 2'd0);

  always_comb begin
    nfull_d  = nfull_q;
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    wr_idx_d = wr_idx_q;
    case ({close, rel})
      2'b10:   nfull_d = nfull_q + 2'd1;
      2'b01:   nfull_d = nfull_q - 2'd1;
      default: nfull_d = nfull_q;
    endcase
    if (close)       wr_idx_d = 3'd0;
    else if (accept) wr_idx_d = wr_idx_q + 3'd1;
    if (close) wbank_d = ~wbank_q;
    if (rel)   rbank_d = ~rbank_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nfull_q  <= 2'd0;
      wbank_q  <= 1'b0;
      rbank_q  <= 1'b0;
      wr_idx_q <= 3'd0;
    end else begin
      nfull_q  <= nfull_d;
      wbank_q  <= wbank_d;
      rbank_q  <= rbank_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  fantasticfft_frame_bank u_bank0 (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (accept && !wbank_q),
    .close_i   (close && !wbank_q),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (fixed_t'(scaled)),
    .pad_i     (pad),
    .x_o       (bx0),
    .padded_o  (bpad0)
  );

  fantasticfft_frame_bank u_bank1 (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (accept && wbank_q),
    .close_i   (close && wbank_q),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (fixed_t'(scaled)),
    .pad_i     (pad),
    .x_o       (bx1),
    .padded_o  (bpad1)
  );

  assign xr         = rbank_q ? bx1 : bx0;
  assign bus.padded = rbank_q ? bpad1 : bpad0;
  assign bus.x0     = xr[0];
  assign bus.x1     = xr[1];
  assign bus.x2     = xr[2];
  assign bus.x3     = xr[3];
  assign bus.x4     = xr[4];
  assign bus.x5     = xr[5];
  assign bus.x6     = xr[6];
  assign bus.x7     = xr[7];
endmodule

// File: tb/tb_fantasticfft_fft8_framer.sv
// Directed bench for the FFT8 framer with a frame-level scoreboard on the unscaled instance.
module tb_fantasticfft_fft8_framer;
  import fantasticfft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fantasticfft_fft8_framer_if bus ();
  fantasticfft_fft8_framer_if bus3 ();

  fantasticfft_fft8_framer #(.PRESCALE(0)) dut (.clk(clk), .rst(rst), .bus(bus));
  fantasticfft_fft8_framer #(.PRESCALE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  wire [127:0] xcat  = {bus.x0, bus.x1, bus.x2, bus.x3, bus.x4, bus.x5, bus.x6, bus.x7};
  wire [127:0] xcat3 = {bus3.x0, bus3.x1, bus3.x2, bus3.x3, bus3.x4, bus3.x5, bus3.x6, bus3.x7};

  // Frame-level reference: builds frames from observed accepts, compares on release.
  logic [127:0] fq[$];
  logic         pq[$];
  int           nq[$];
  fixed_t       cur[8];
  int           cnt = 0;
  int           s_in = 0;
  int           s_out = 0;
  logic         hold_prev = 1'b0;
  logic [127:0] x_prev;
  logic         pad_prev;

  always @(negedge clk) begin
    if (rst) begin
      foreach (nq[i]) s_in -= nq[i];
      fq.delete(); pq.delete(); nq.delete();
      cnt = 0;
      hold_prev = 1'b0;
    end else begin
      check("sb_isValid", bus.isValid, fq.size() > 0);
      check("sb_s_ready", bus.s_ready, fq.size() < 2);
      check("nfull_le2", dut.nfull_q <= 2'd2, 1'b1);
      if (hold_prev) begin
        check("hold_x", xcat, x_prev);
        check("hold_padded", bus.padded, pad_prev);
      end
      hold_prev = bus.isValid && !bus.fft_ready;
      x_prev    = xcat;
      pad_prev  = bus.padded;
      if (bus.isValid && bus.fft_ready && fq.size() > 0) begin
        check("sb_frame", xcat, fq[0]);
        check("sb_padded", bus.padded, pq[0]);
        s_out += nq[0];
        void'(fq.pop_front()); void'(pq.pop_front()); void'(nq.pop_front());
      end
      if (bus.s_valid && bus.s_ready) begin
        cur[cnt] = bus.s_data;
        cnt++;
        if (cnt == 8 || bus.s_last) begin
          logic [127:0] f;
          f = '0;
          for (int i = 0; i < 8; i++) if (i < cnt) f[127-16*i -: 16] = cur[i];
          fq.push_back(f);
          pq.push_back(cnt < 8);
          nq.push_back(cnt);
          s_in += cnt;
          cnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    bus.s_last  = last;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.s_ready;
      step();
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  initial begin
    bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.fft_ready = 1'b1;
    bus3.s_data = '0; bus3.s_valid = 1'b0; bus3.s_last = 1'b0; bus3.fft_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_isValid", bus.isValid, 1'b0);
    check("rst_padded", bus.padded, 1'b0);
    check("rst_x", xcat, '0);
    check("rst_s_ready", bus.s_ready, 1'b1);
    step();

    // Basic frame
    for (int i = 1; i <= 8; i++) send(16'(i * 256), 1'b0);
    @(negedge clk);
    check("basic_isValid", bus.isValid, 1'b1);
    check("basic_x", xcat, 128'h0100_0200_0300_0400_0500_0600_0700_0800);
    check("basic_padded", bus.padded, 1'b0);
    step();
    @(negedge clk);
    check("basic_one_cycle", bus.isValid, 1'b0);
    step();

    // Pre-scale on the second instance
    bus3.s_data = 16'h0800; bus3.s_valid = 1'b1;
    step();
    bus3.s_data = 16'hF800; bus3.s_last = 1'b1;
    step();
    bus3.s_valid = 1'b0; bus3.s_last = 1'b0;
    @(negedge clk);
    check("pre_isValid", bus3.isValid, 1'b1);
    check("pre_x", xcat3, 128'h0100_FF00_0000_0000_0000_0000_0000_0000);
    check("pre_padded", bus3.padded, 1'b1);
    step();
    bus3.fft_ready = 1'b1;

    // Backpressure
    bus.fft_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h1000 + 16'(i), 1'b0);
    for (int i = 0; i < 8; i++) send(16'h2000 + 16'(i), 1'b0);
    bus.s_data = 16'h3000; bus.s_valid = 1'b1;
    @(negedge clk);
    check("bp_17th_ready", bus.s_ready, 1'b0);
    check("bp_x_frame1", xcat, 128'h1000_1001_1002_1003_1004_1005_1006_1007);
    step();
    @(negedge clk);
    check("bp_hold_x0", bus.x0, 16'h1000);
    step();
    bus.fft_ready = 1'b1;
    @(negedge clk);
    check("bp_full_ready", bus.s_ready, 1'b0);
    step();
    @(negedge clk);
    check("bp_ready_after_rel", bus.s_ready, 1'b1);
    check("bp_x_frame2", xcat, 128'h2000_2001_2002_2003_2004_2005_2006_2007);
    step();
    bus.s_valid = 1'b0;
    send(16'h3001, 1'b1);
    step();
    step();

    // Short frame and follow-up
    bus.fft_ready = 1'b0;
    send(16'h0100, 1'b0);
    send(16'h0200, 1'b0);
    send(16'h0300, 1'b1);
    @(negedge clk);
    check("short_isValid", bus.isValid, 1'b1);
    check("short_x", xcat, 128'h0100_0200_0300_0000_0000_0000_0000_0000);
    check("short_padded", bus.padded, 1'b1);
    step();
    bus.fft_ready = 1'b1;
    step();
    bus.fft_ready = 1'b0;
    send(16'h0900, 1'b1);
    @(negedge clk);
    check("follow_x", xcat, 128'h0900_0000_0000_0000_0000_0000_0000_0000);
    step();
    bus.fft_ready = 1'b1;
    step();

    // Reset mid-frame
    for (int i = 0; i < 5; i++) send(16'h5000 + 16'(i), 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_isValid", bus.isValid, 1'b0);
    check("mrst_x", xcat, '0);
    check("mrst_padded", bus.padded, 1'b0);
    check("mrst_s_ready", bus.s_ready, 1'b1);
    step();
    bus.fft_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h0A00 + 16'(i), 1'b0);
    @(negedge clk);
    check("mrst_clean_x", xcat, 128'h0A00_0A01_0A02_0A03_0A04_0A05_0A06_0A07);
    check("mrst_clean_padded", bus.padded, 1'b0);
    step();

    // Close and release on the same edge
    for (int i = 0; i < 7; i++) send(16'h6100 + 16'(i), 1'b0);
    bus.fft_ready = 1'b1;
    send(16'h6107, 1'b0);
    bus.fft_ready = 1'b0;
    @(negedge clk);
    check("sim_isValid", bus.isValid, 1'b1);
    check("sim_s_ready", bus.s_ready, 1'b1);
    check("sim_x", xcat, 128'h6100_6101_6102_6103_6104_6105_6106_6107);
    step();
    for (int i = 0; i < 8; i++) send(16'h6200 + 16'(i), 1'b0);
    @(negedge clk);
    check("sim_then_full", bus.s_ready, 1'b0);
    step();
    bus.fft_ready = 1'b1;
    repeat (4) step();

    @(negedge clk);
    check("sb_empty", fq.size(), 0);
    check("sb_partial", cnt, 0);
    check("sb_count", s_out, s_in);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
